// File: rtl/rpsc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rpsc_seq_pkg
// Brief    : Shared state encoding, stage indices and helpers for the RPSC
//            transmitter power sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package rpsc_seq_pkg;

    typedef enum logic [3:0] {
        ST_OFF        = 4'd0,
        ST_SB_STEP    = 4'd1,
        ST_SB_READY   = 4'd2,
        ST_HV_STEP    = 4'd3,
        ST_HV_READY   = 4'd4,
        ST_SHUT_HV    = 4'd5,
        ST_SHUT_SB    = 4'd6,
        ST_FAULT_COOL = 4'd7,
        ST_FAULT      = 4'd8
    } state_e;

    localparam int STG_FAN    = 0;
    localparam int STG_DR_AMP = 1;
    localparam int STG_G1     = 2;
    localparam int STG_CA     = 3;
    localparam int STG_G2     = 4;
    localparam int STG_ANODE  = 5;
    localparam int N_STAGES   = 6;
    localparam int N_SB       = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Lowest set bit index; used to report the first stage that dropped out.
    function automatic logic [2:0] lowest_set(input logic [N_STAGES-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = N_STAGES - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rpsc_step_timer.sv
`default_nettype none
// ============================================================================
// Module   : rpsc_step_timer
// Brief    : Loadable saturating down-counter; expired flags the edge on
//            which a value loaded N edges earlier runs out.
// Revision : 1.0 - initial release
// ============================================================================
module rpsc_step_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign expired = (r_count <= WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/rpsc_power_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rpsc_power_sequencer
// Brief    : RPSC transmitter power sequencer: staged enable/ack bring-up,
//            reverse-order shutdown, ack timeout and dropout fault handling.
// Config   : RPSC_SEQ_HV_INTERLOCK_EN adds the hv_interlock_n permit input.
// Revision : 1.0 - initial release
// ============================================================================
module rpsc_power_sequencer
    import rpsc_seq_pkg::*;
#(
    parameter int STEP_DLY    = 4,
    parameter int ACK_TIMEOUT = 1000,
    parameter int COOL_DLY    = 5000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sb_on_req,
    input  logic                hv_on_req,
    input  logic                hv_off_req,
    input  logic                off_req,
    input  logic                fault_clr,
`ifdef RPSC_SEQ_HV_INTERLOCK_EN
    input  logic                hv_interlock_n,
`endif
    input  logic [N_STAGES-1:0] status_n,
    output logic [N_STAGES-1:0] en,
    output logic                sb_ready,
    output logic                hv_ready,
    output logic                busy,
    output logic                fault,
    output logic [2:0]          fault_stage,
    output logic                fault_dropout
);

    localparam int c_CNT_MAX = max3(STEP_DLY, ACK_TIMEOUT, COOL_DLY);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_LD_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_LD_STEP = c_CNT_W'(STEP_DLY);
    localparam logic [c_CNT_W-1:0] c_LD_ACK  = c_CNT_W'(ACK_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_LD_COOL = c_CNT_W'(COOL_DLY);
    localparam logic [2:0]         c_LAST_SB = 3'(STG_CA);
    localparam logic [2:0]         c_LAST_HV = 3'(STG_ANODE);
    localparam logic [2:0]         c_FIRST_HV = 3'(STG_G2);
    localparam logic [2:0]         c_FIRST_SB = 3'(STG_FAN);

    state_e                r_state, w_state_nxt;
    logic [2:0]            r_stage, w_stage_nxt;
    logic [N_STAGES-1:0]   r_en, w_en_nxt;
    logic [N_STAGES-1:0]   r_acked, w_ack_set;
    logic                  r_fault, w_fault_nxt;
    logic [2:0]            r_fault_stage, w_fstage_nxt;
    logic                  r_fault_dropout, w_fdrop_nxt;
    logic                  r_sb_ready, r_hv_ready, r_busy;
    logic                  w_load, w_expired;
    logic [c_CNT_W-1:0]    w_load_val;
    logic                  w_hv_permit, w_hv_off;
    logic                  w_in_step, w_monitor, w_timeout, w_dropout;
    logic [N_STAGES-1:0]   w_drop_vec;

`ifdef RPSC_SEQ_HV_INTERLOCK_EN
    // Losing the permit while HV is up is an orderly HV shutdown, not a fault.
    assign w_hv_permit = ~hv_interlock_n;
    assign w_hv_off    = hv_off_req | hv_interlock_n;
`else
    assign w_hv_permit = 1'b1;
    assign w_hv_off    = hv_off_req;
`endif

    rpsc_step_timer #(
        .WIDTH   (c_CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (w_load),
        .value   (w_load_val),
        .expired (w_expired)
    );

    assign w_in_step  = (r_state == ST_SB_STEP) || (r_state == ST_HV_STEP);
    assign w_monitor  = !((r_state == ST_OFF) || (r_state == ST_FAULT_COOL) || (r_state == ST_FAULT));
    assign w_timeout  = w_in_step && !r_acked[r_stage] && status_n[r_stage] && w_expired;
    assign w_drop_vec = r_en & r_acked & status_n;
    assign w_dropout  = w_monitor && (|w_drop_vec);

    always_comb begin
        w_state_nxt  = r_state;
        w_stage_nxt  = r_stage;
        w_en_nxt     = r_en;
        w_ack_set    = '0;
        w_load       = 1'b0;
        w_load_val   = c_LD_ONE;
        w_fault_nxt  = r_fault;
        w_fstage_nxt = r_fault_stage;
        w_fdrop_nxt  = r_fault_dropout;
        if (w_dropout || w_timeout) begin
            w_state_nxt  = ST_FAULT_COOL;
            w_en_nxt     = {{(N_STAGES-1){1'b0}}, r_en[STG_FAN]};
            w_load       = 1'b1;
            w_load_val   = c_LD_COOL;
            w_fault_nxt  = 1'b1;
            w_fstage_nxt = w_dropout ? lowest_set(w_drop_vec) : r_stage;
            w_fdrop_nxt  = w_dropout;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (sb_on_req) begin
                        w_state_nxt          = ST_SB_STEP;
                        w_stage_nxt          = c_FIRST_SB;
                        w_en_nxt[STG_FAN]    = 1'b1;
                        w_load               = 1'b1;
                        w_load_val           = c_LD_ACK;
                    end
                end
                ST_SB_STEP, ST_HV_STEP: begin
                    if (off_req) begin
                        w_state_nxt = ST_SHUT_SB;
                        w_load      = 1'b1;
                    end else if ((r_state == ST_HV_STEP) && w_hv_off) begin
                        w_state_nxt = ST_SHUT_HV;
                        w_load      = 1'b1;
                    end else if (!r_acked[r_stage]) begin
                        if (!status_n[r_stage]) begin
                            w_ack_set[r_stage] = 1'b1;
                            w_load             = 1'b1;
                            w_load_val         = c_LD_STEP;
                        end
                    end else if (w_expired) begin
                        if (r_stage == c_LAST_SB) begin
                            w_state_nxt = ST_SB_READY;
                        end else if (r_stage == c_LAST_HV) begin
                            w_state_nxt = ST_HV_READY;
                        end else begin
                            w_stage_nxt                 = r_stage + 3'd1;
                            w_en_nxt[r_stage + 3'd1]    = 1'b1;
                            w_load                      = 1'b1;
                            w_load_val                  = c_LD_ACK;
                        end
                    end
                end
                ST_SB_READY: begin
                    if (off_req) begin
                        w_state_nxt = ST_SHUT_SB;
                        w_load      = 1'b1;
                    end else if (hv_on_req && w_hv_permit) begin
                        w_state_nxt       = ST_HV_STEP;
                        w_stage_nxt       = c_FIRST_HV;
                        w_en_nxt[STG_G2]  = 1'b1;
                        w_load            = 1'b1;
                        w_load_val        = c_LD_ACK;
                    end
                end
                ST_HV_READY: begin
                    if (off_req) begin
                        w_state_nxt = ST_SHUT_SB;
                        w_load      = 1'b1;
                    end else if (w_hv_off) begin
                        w_state_nxt = ST_SHUT_HV;
                        w_load      = 1'b1;
                    end
                end
                // r_stage always points at the highest enabled stage while unwinding.
                ST_SHUT_HV, ST_SHUT_SB: begin
                    if ((r_state == ST_SHUT_HV) && off_req) begin
                        w_state_nxt = ST_SHUT_SB;
                    end else if (w_expired) begin
                        w_en_nxt[r_stage] = 1'b0;
                        if ((r_state == ST_SHUT_HV) && (r_stage == c_FIRST_HV)) begin
                            w_state_nxt = ST_SB_READY;
                            w_stage_nxt = c_LAST_SB;
                        end else if (r_stage == c_FIRST_SB) begin
                            w_state_nxt = ST_OFF;
                        end else begin
                            w_stage_nxt = r_stage - 3'd1;
                            w_load      = 1'b1;
                            w_load_val  = c_LD_STEP;
                        end
                    end
                end
                ST_FAULT_COOL: begin
                    if (w_expired) begin
                        w_en_nxt[STG_FAN] = 1'b0;
                        w_state_nxt       = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr && (status_n == {N_STAGES{1'b1}})) begin
                        w_state_nxt  = ST_OFF;
                        w_fault_nxt  = 1'b0;
                        w_fstage_nxt = 3'd0;
                        w_fdrop_nxt  = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                    w_en_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_OFF;
            r_stage         <= 3'd0;
            r_en            <= '0;
            r_acked         <= '0;
            r_fault         <= 1'b0;
            r_fault_stage   <= 3'd0;
            r_fault_dropout <= 1'b0;
            r_sb_ready      <= 1'b0;
            r_hv_ready      <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_stage         <= w_stage_nxt;
            r_en            <= w_en_nxt;
            r_acked         <= (r_acked | w_ack_set) & w_en_nxt;
            r_fault         <= w_fault_nxt;
            r_fault_stage   <= w_fstage_nxt;
            r_fault_dropout <= w_fdrop_nxt;
            r_sb_ready      <= w_state_nxt inside {ST_SB_READY, ST_HV_STEP, ST_HV_READY, ST_SHUT_HV};
            r_hv_ready      <= (w_state_nxt == ST_HV_READY);
            r_busy          <= w_state_nxt inside {ST_SB_STEP, ST_HV_STEP, ST_SHUT_HV, ST_SHUT_SB,
                                                   ST_FAULT_COOL};
        end
    end

    assign en            = r_en;
    assign sb_ready      = r_sb_ready;
    assign hv_ready      = r_hv_ready;
    assign busy          = r_busy;
    assign fault         = r_fault;
    assign fault_stage   = r_fault_stage;
    assign fault_dropout = r_fault_dropout;

endmodule
`default_nettype wire

// File: tb/tb_rpsc_power_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rpsc_power_sequencer
// Brief    : Directed bench for rpsc_power_sequencer; a stage model acks each
//            enable two cycles after it rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rpsc_power_sequencer;

    localparam int STEP_DLY    = 4;
    localparam int ACK_TIMEOUT = 10;
    localparam int COOL_DLY    = 8;

    localparam logic [4:0] R_SB    = 5'b00001;
    localparam logic [4:0] R_HVON  = 5'b00010;
    localparam logic [4:0] R_HVOFF = 5'b00100;
    localparam logic [4:0] R_OFF   = 5'b01000;
    localparam logic [4:0] R_CLR   = 5'b10000;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] req   = '0;
    logic       sb_on_req, hv_on_req, hv_off_req, off_req, fault_clr;
    logic [5:0] status_n;
    logic [5:0] force_hi = '0;
    logic [5:0] force_lo = '0;
    logic [5:0] en;
    logic       sb_ready, hv_ready, busy, fault, fault_dropout;
    logic [2:0] fault_stage;
`ifdef RPSC_SEQ_HV_INTERLOCK_EN
    logic       hv_interlock_n = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [1:0] ack_cnt [6] = '{default: 2'd0};

    assign {fault_clr, off_req, hv_off_req, hv_on_req, sb_on_req} = req;

    rpsc_power_sequencer #(
        .STEP_DLY      (STEP_DLY),
        .ACK_TIMEOUT   (ACK_TIMEOUT),
        .COOL_DLY      (COOL_DLY)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sb_on_req     (sb_on_req),
        .hv_on_req     (hv_on_req),
        .hv_off_req    (hv_off_req),
        .off_req       (off_req),
        .fault_clr     (fault_clr),
`ifdef RPSC_SEQ_HV_INTERLOCK_EN
        .hv_interlock_n(hv_interlock_n),
`endif
        .status_n      (status_n),
        .en            (en),
        .sb_ready      (sb_ready),
        .hv_ready      (hv_ready),
        .busy          (busy),
        .fault         (fault),
        .fault_stage   (fault_stage),
        .fault_dropout (fault_dropout)
    );

    always #5 clk = ~clk;

    // Stage model: ack low from the second edge after the enable rises.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 6; k++) begin
            if (!en[k]) ack_cnt[k] = 2'd0;
            else if (ack_cnt[k] < 2'd2) ack_cnt[k] = ack_cnt[k] + 2'd1;
        end
    end

    always_comb begin
        status_n = '1;
        for (int k = 0; k < 6; k++) begin
            status_n[k] = ((ack_cnt[k] < 2'd2) | force_hi[k]) & ~force_lo[k];
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [4:0] r);
        req = r;
        cyc(1);
        req = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        cyc(3);
        check("rst_en", 32'(en), 32'h00);
        check("rst_sb_ready", 32'(sb_ready), 0);
        check("rst_hv_ready", 32'(hv_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_fault_stage", 32'(fault_stage), 0);
        check("rst_fault_dropout", 32'(fault_dropout), 0);
        reset = 1'b1;
        cyc(2);

        pulse(R_HVON);
        check("off_hvon_dropped_en", 32'(en), 32'h00);
        check("off_hvon_dropped_busy", 32'(busy), 0);

        // Standby bring-up: stage k enables at A+6k, ready at A+24.
        pulse(R_SB);
        check("t1_en_accept", 32'(en), 32'h01);
        check("t1_busy", 32'(busy), 1);
        cyc(5);
        check("t1_en_settling", 32'(en), 32'h01);
        cyc(1);
        check("t1_en_stage1", 32'(en), 32'h03);
        cyc(17);
        check("t1_en_stage3", 32'(en), 32'h0F);
        check("t1_sb_ready_early", 32'(sb_ready), 0);
        cyc(1);
        check("t1_sb_ready", 32'(sb_ready), 1);
        check("t1_busy_done", 32'(busy), 0);

        // HV bring-up then HV-only shutdown.
        pulse(R_HVON);
        check("t2_en_g2", 32'(en), 32'h1F);
        cyc(6);
        check("t2_en_anode", 32'(en), 32'h3F);
        cyc(6);
        check("t2_hv_ready", 32'(hv_ready), 1);
        check("t2_busy_ready", 32'(busy), 0);
        pulse(R_HVOFF);
        check("t2_shut_en_hold", 32'(en), 32'h3F);
        check("t2_shut_busy", 32'(busy), 1);
        check("t2_shut_hv_ready", 32'(hv_ready), 0);
        cyc(1);
        check("t2_shut_en5", 32'(en), 32'h1F);
        cyc(3);
        check("t2_shut_en5_hold", 32'(en), 32'h1F);
        cyc(1);
        check("t2_shut_en4", 32'(en), 32'h0F);
        check("t2_back_sb_ready", 32'(sb_ready), 1);
        check("t2_back_busy", 32'(busy), 0);

        // off_req beats hv_on_req on the same edge.
        pulse(R_OFF | R_HVON);
        check("t5_prio_en", 32'(en), 32'h0F);
        check("t5_prio_busy", 32'(busy), 1);
        cyc(1);
        check("t5_shut_en3", 32'(en), 32'h07);
        cyc(11);
        check("t5_shut_en1", 32'(en), 32'h01);
        cyc(1);
        check("t5_shut_off", 32'(en), 32'h00);
        check("t5_shut_busy", 32'(busy), 0);
        check("t5_shut_sb_ready", 32'(sb_ready), 0);

        // Ack timeout on stage 2 (enabled at A+12, times out at A+22).
        force_hi = 6'h04;
        pulse(R_SB);
        cyc(21);
        check("t3_no_fault_yet", 32'(fault), 0);
        check("t3_en_waiting", 32'(en), 32'h07);
        cyc(1);
        check("t3_fault", 32'(fault), 1);
        check("t3_fault_stage", 32'(fault_stage), 2);
        check("t3_fault_dropout", 32'(fault_dropout), 0);
        check("t3_en_cool", 32'(en), 32'h01);
        check("t3_busy_cool", 32'(busy), 1);
        cyc(7);
        check("t3_fan_held", 32'(en), 32'h01);
        cyc(1);
        check("t3_fan_off", 32'(en), 32'h00);
        check("t3_busy_fault", 32'(busy), 0);
        check("t3_fault_sticky", 32'(fault), 1);
        force_hi = '0;
        force_lo = 6'h01;
        pulse(R_CLR);
        check("t3_clr_blocked", 32'(fault), 1);
        force_lo = '0;
        pulse(R_CLR);
        check("t3_clr_ok", 32'(fault), 0);

        // Dropout of stage 4 in HV_READY.
        pulse(R_SB);
        cyc(24);
        pulse(R_HVON);
        cyc(12);
        check("t4_hv_ready", 32'(hv_ready), 1);
        force_hi = 6'h10;
        cyc(1);
        force_hi = '0;
        check("t4_fault", 32'(fault), 1);
        check("t4_fault_dropout", 32'(fault_dropout), 1);
        check("t4_fault_stage", 32'(fault_stage), 4);
        check("t4_en_cool", 32'(en), 32'h01);
        check("t4_hv_ready_drop", 32'(hv_ready), 0);
        pulse(R_CLR);
        check("t4_clr_in_cool_ignored", 32'(fault), 1);
        cyc(7);
        check("t4_fan_off", 32'(en), 32'h00);
        pulse(R_CLR);
        check("t4_clr_after_cool", 32'(fault), 0);

        // Asynchronous reset in the middle of HV_STEP.
        pulse(R_SB);
        cyc(24);
        pulse(R_HVON);
        cyc(2);
        check("t5_hv_step_en", 32'(en), 32'h1F);
        reset = 1'b0;
        #1;
        check("t5_async_rst_en", 32'(en), 32'h00);
        check("t5_async_rst_busy", 32'(busy), 0);
        check("t5_async_rst_sb_ready", 32'(sb_ready), 0);
        cyc(2);
        reset = 1'b1;
        cyc(2);
        pulse(R_SB);
        check("t5_restart_en", 32'(en), 32'h01);
        pulse(R_OFF);
        cyc(1);
        check("t5_restart_off_en", 32'(en), 32'h00);
        check("t5_restart_off_busy", 32'(busy), 0);

`ifdef RPSC_SEQ_HV_INTERLOCK_EN
        pulse(R_SB);
        cyc(24);
        hv_interlock_n = 1'b1;
        pulse(R_HVON);
        check("t6_blocked_en", 32'(en), 32'h0F);
        check("t6_blocked_busy", 32'(busy), 0);
        hv_interlock_n = 1'b0;
        pulse(R_HVON);
        check("t6_permit_en", 32'(en), 32'h1F);
        cyc(12);
        check("t6_hv_ready", 32'(hv_ready), 1);
        hv_interlock_n = 1'b1;
        cyc(1);
        check("t6_release_busy", 32'(busy), 1);
        check("t6_release_hv_ready", 32'(hv_ready), 0);
        cyc(1);
        check("t6_release_en5", 32'(en), 32'h1F);
        cyc(4);
        check("t6_release_en4", 32'(en), 32'h0F);
        check("t6_release_no_fault", 32'(fault), 0);
        check("t6_release_sb_ready", 32'(sb_ready), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
